// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Glyph table is active-high gfedcba; pin polarity is applied in the top.
package sseg_pkg;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam logic [3:0] DIG_OFF = 4'h0;

    // Entry n holds the glyph for nibble n (F is the leftmost element).
    localparam logic [15:0][6:0] GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/sseg_nibble_decode.sv
// Combinational hex nibble to seven-segment glyph lookup.
module sseg_nibble_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = GLYPH[nib_i];

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-aligned loads.
// Define SSEG_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int CLK_FREQ       = 16_000_000,
    parameter int SCAN_HZ        = 2_000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] value,
    input  logic        value_valid,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp,
    output logic [7:0]  seg,
    output logic [3:0]  dig,
    output logic        load_ack
);

    localparam int DIV = CLK_FREQ / SCAN_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TC  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLK = CW'(BLANK_CYCLES);
    localparam logic [7:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    if (BLANK_CYCLES >= DIV) begin : g_bad_blank
        $error("sseg_scan_driver: BLANK_CYCLES must be less than DIV");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    idx_q, idx_d;
    scan_state_t   state_q;
    logic [15:0]   shadow_q;
    logic [15:0]   pending_q;
    logic          pend_q;
    logic          ack_q;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;

    logic       tc;
    logic       wrap;
    logic [3:0] nib;
    logic [6:0] glyph;
    logic [6:0] seg7;

    assign tc   = (cnt_q == TC);
    assign wrap = tc && (idx_q == 2'd3);
    assign nib  = shadow_q[{idx_q, 2'b00} +: 4];

    sseg_nibble_decode u_dec (
        .nib_i   (nib),
        .glyph_o (glyph)
    );

`ifdef SSEG_LZ_BLANK_EN
    logic [3:0] lz;
    always_comb begin
        lz    = 4'b0000;
        lz[3] = (shadow_q[15:12] == 4'h0);
        lz[2] = lz[3] && (shadow_q[11:8] == 4'h0);
        lz[1] = lz[2] && (shadow_q[7:4] == 4'h0);
    end
    assign seg7 = lz[idx_q] ? 7'h00 : glyph;
`else
    assign seg7 = glyph;
`endif

    always_comb begin
        cnt_d = tc ? '0 : cnt_q + CW'(1);
        idx_d = tc ? idx_q + 2'd1 : idx_q;
        seg_d = {dp[idx_q], seg7};
        dig_d = DIG_OFF;
        if (state_q == DRIVE && digit_en[idx_q]) begin
            dig_d = 4'b0001 << idx_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            state_q   <= BLANK;
            shadow_q  <= '0;
            pending_q <= '0;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            seg_q     <= SEG_OFF ^ SEG_INV;
            dig_q     <= DIG_OFF ^ DIG_INV;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= (cnt_d < BLK) ? BLANK : DRIVE;
            seg_q   <= seg_d ^ SEG_INV;
            dig_q   <= dig_d ^ DIG_INV;
            ack_q   <= 1'b0;
            // A strobe coinciding with the frame wrap skips the pending slot.
            if (wrap && (value_valid || pend_q)) begin
                shadow_q <= value_valid ? value : pending_q;
                pend_q   <= 1'b0;
                ack_q    <= 1'b1;
            end else if (value_valid) begin
                pending_q <= value;
                pend_q    <= 1'b1;
            end
        end
    end

    assign seg      = seg_q;
    assign dig      = dig_q;
    assign load_ack = ack_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (DIV=10, BLANK_CYCLES=2).
// Expected pins come from a cycle-position model of frames, slots and loads.
module tb_sseg_scan_driver;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] value;
    logic        value_valid;
    logic [3:0]  digit_en;
    logic [3:0]  dp;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        load_ack;

    int checks = 0;
    int errors = 0;

    // Model: p = cycle index since reset release; disp = value of current frame.
    int          p;
    logic [15:0] disp;
    logic [15:0] win_val;
    logic        win_has;

    logic [6:0] glyph_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    sseg_scan_driver #(
        .CLK_FREQ       (1000),
        .SCAN_HZ        (100),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (0),
        .DIG_ACTIVE_LOW (0)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .value       (value),
        .value_valid (value_valid),
        .digit_en    (digit_en),
        .dp          (dp),
        .seg         (seg),
        .dig         (dig),
        .load_ack    (load_ack)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at p=%0d: got %h expected %h", tag, p, obs, exp);
        end
    endtask

    task automatic model_reset();
        p       = 0;
        disp    = 16'h0;
        win_val = 16'h0;
        win_has = 1'b0;
    endtask

    // One clock: drive inputs, advance, then compare against the model.
    task automatic cycle(input logic vv, input logic [15:0] v);
        int          slot;
        int          pos;
        logic [15:0] hi;
        logic [6:0]  g;
        logic [7:0]  e_seg;
        logic [3:0]  e_dig;
        logic        e_ack;
        value_valid = vv;
        value       = v;
        slot = (p / 10) % 4;
        pos  = p % 10;
        hi   = disp >> (4 * slot);
        g    = glyph_tab[hi[3:0]];
`ifdef SSEG_LZ_BLANK_EN
        if (slot > 0 && hi == 16'h0) g = 7'h00;
`endif
        e_seg = {dp[slot], g};
        e_dig = (pos >= 2 && digit_en[slot]) ? 4'(1 << slot) : 4'h0;
        if (vv) begin
            win_val = v;
            win_has = 1'b1;
        end
        e_ack = 1'b0;
        if (p % 40 == 39) begin
            e_ack = win_has;
            if (win_has) disp = win_val;
            win_has = 1'b0;
        end
        @(posedge CLK);
        #1;
        chk("seg", seg, e_seg);
        chk("dig", {4'h0, dig}, {4'h0, e_dig});
        chk("load_ack", {7'h0, load_ack}, {7'h0, e_ack});
        p++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0);
    endtask

    task automatic run_to(input int frame_pos);
        for (int i = 0; i < 40 && (p % 40) != frame_pos; i++) begin
            cycle(1'b0, 16'h0);
        end
    endtask

    task automatic async_reset();
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_seg", seg, 8'h00);
        chk("rst_dig", {4'h0, dig}, 8'h00);
        chk("rst_ack", {7'h0, load_ack}, 8'h00);
        @(posedge CLK);
        #1;
        chk("rst_hold_seg", seg, 8'h00);
        chk("rst_hold_dig", {4'h0, dig}, 8'h00);
        RST_N = 1'b1;
        model_reset();
    endtask

    initial begin
        RST_N       = 1'b0;
        value       = 16'h0;
        value_valid = 1'b0;
        digit_en    = 4'hF;
        dp          = 4'h0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("init_seg", seg, 8'h00);
        chk("init_dig", {4'h0, dig}, 8'h00);
        chk("init_ack", {7'h0, load_ack}, 8'h00);
        RST_N = 1'b1;

        // Mid-frame load of 1234
        run(5);
        cycle(1'b1, 16'h1234);
        run(100);

        // Two strobes in one frame: last wins, one ack
        run_to(10);
        cycle(1'b1, 16'hAAAA);
        run(5);
        cycle(1'b1, 16'h00F0);
        run(80);

        // Strobe in the wrap cycle
        run_to(39);
        cycle(1'b1, 16'h5555);
        run(45);

        // Reset during DRIVE of digit 2
        run_to(25);
        async_reset();
        run(45);

        // Disabled digit 2 with a mostly-zero value
        digit_en = 4'b1011;
        cycle(1'b1, 16'h0040);
        run(90);

        // Randomized traffic
        for (int i = 0; i < 700; i++) begin
            logic [15:0] rv;
            dp = 4'($urandom);
            if ($urandom_range(0, 49) == 0) digit_en = 4'($urandom);
            rv = 16'($urandom);
            if ($urandom_range(0, 1) == 0) rv = rv >> (4 * $urandom_range(1, 4));
            cycle($urandom_range(0, 24) == 0, rv);
        end
        dp = 4'h0;
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
